// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch/mem-wait hazard control for the 5-stage MIPS pipe.
// Define STALL_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic [7:0]       ctrl_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             dmem_busy_i,
  output logic [7:0]       ctrl_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             pipe_hold_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic [1:0] {INIT, RUN, LU_STALL, MEM_WAIT} state_t;
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       init, lu;
  assign init = state_q == INIT;
  assign lu = idex_memread_i && idex_rt_i != 5'd0 &&
              (idex_rt_i == ifid_rs_i || (ifid_uses_rt_i && idex_rt_i == ifid_rt_i));
  assign timeout_o = timeout_q;
  // Every non-INIT state shares the RUN priority; states only differ in wait counting.
  always_comb begin
    pc_write_o   = !init && !dmem_busy_i && !lu;
    ifid_write_o = pc_write_o;
    pipe_hold_o  = !init && dmem_busy_i;
    ifid_flush_o = init || (!dmem_busy_i && !lu && (branch_taken_i || jump_i));
    ctrl_o       = (init || (!dmem_busy_i && lu)) ? 8'h00 : ctrl_i;
    state_d      = init ? RUN : dmem_busy_i ? MEM_WAIT : lu ? LU_STALL : RUN;
    wait_d       = (init || !dmem_busy_i) ? 8'd0 :
                   state_q != MEM_WAIT ? 8'd1 :
                   wait_q == MAX_W ? wait_q : wait_q + 8'd1;
    timeout_d    = timeout_q || wait_d == MAX_W;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(!init && !pc_write_o);
      flush_q <= flush_q + CNT_W'(!init && ifid_flush_o);
    end
  end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core; it drives the 8-bit control word into the ID/EX register. That word is the bubble-mux output, with layout [7]RegDst [6:5]ALUOp [4]ALUSrc [3:2]M [1:0]WB.
- Detects load-use hazards, branch/jump flushes and data-memory wait stalls.
- Produces PC/IF-ID write enables, IF/ID flush, whole-pipe hold and the bubbled control word.
- Contains a small FSM plus a memory-wait watchdog.

Parameters:
MAX_WAIT, 16, max consecutive dmem_busy_i cycles before timeout_o asserts (2..255)
CNT_W, 16, width of the stall/flush performance counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
ifid_rs_i  in  5  rs field of instruction in IF/ID
ifid_rt_i  in  5  rt field of instruction in IF/ID
ifid_uses_rt_i  in  1  instruction in ID reads rt (R-type, sw, beq)
ctrl_i  in  8  control word from main decoder
idex_memread_i  in  1  ID/EX M[1] (MemRead) of instruction in EX
idex_rt_i  in  5  destination rt of instruction in EX
branch_taken_i  in  1  branch in ID resolved taken
jump_i  in  1  jump in ID
dmem_busy_i  in  1  data memory not ready this cycle
ctrl_o  out  8  control word to ID/EX (0 = bubble)
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID clear (insert nop)
pipe_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
timeout_o  out  1  sticky watchdog error
stall_cnt_o  out  CNT_W  load-use + mem-wait stall cycles (STALL_CNT_EN only)
flush_cnt_o  out  CNT_W  flush events (STALL_CNT_EN only)

Behaviour:
- The FSM has states INIT, RUN, LU_STALL and MEM_WAIT. Outputs are combinational from state and inputs; the state, wait counter and timeout are registered.
- Reset (rst_n low at an edge):
  - state goes to INIT, the wait counter to 0, timeout_o to 0 and the counters to 0.
  - Reset mid-stall abandons the stall with no residue.
- INIT (exactly one cycle after reset):
  - ctrl_o=0, pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, pipe_hold_o=0.
  - Next state is RUN.
- Load-use hazard (lu): idex_memread_i and idex_rt_i!=0 and (idex_rt_i==ifid_rs_i or (ifid_uses_rt_i and idex_rt_i==ifid_rt_i)).
- Priority in RUN, highest first: dmem_busy_i, then lu, then branch_taken_i|jump_i, then normal.
  - dmem_busy_i:
    - pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, ctrl_o=ctrl_i, ifid_flush_o=0.
    - Next state MEM_WAIT; the wait counter loads 1.
  - lu:
    - pc_write_o=0, ifid_write_o=0, ctrl_o=0 (bubble), ifid_flush_o=0.
    - Next state LU_STALL.
    - A coincident branch/jump is NOT flushed; the branch is re-evaluated next cycle.
  - branch/jump:
    - pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, ctrl_o=ctrl_i.
    - Remains in RUN.
  - normal:
    - pc_write_o=1, ifid_write_o=1, ctrl_o=ctrl_i, flush 0, hold 0.
- LU_STALL: one cycle of the same outputs as RUN, with lu evaluated again. The load has now advanced, so lu is normally false and the state returns to RUN. Back-to-back lu stays in LU_STALL; dmem_busy_i still takes priority.
- MEM_WAIT:
  - While dmem_busy_i: outputs as the RUN busy case; the wait counter increments and saturates at MAX_WAIT.
  - When the counter reaches MAX_WAIT, timeout_o sets and stays set until reset. The stall continues regardless.
  - When dmem_busy_i is low: state returns to RUN this cycle and outputs are evaluated as in RUN; the wait counter clears.
- Register 0 never causes a hazard.

Optional Feature:
STALL_CNT_EN:
- Defined:
  - stall_cnt_o increments on every cycle with pc_write_o=0 outside INIT.
  - flush_cnt_o increments on every cycle with ifid_flush_o=1 outside INIT.
  - Both wrap modulo 2^CNT_W.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset release: rst_n low for 2 edges, then high -> first cycle INIT (ctrl_o=0, ifid_flush_o=1, pc_write_o=0); next cycle RUN, ctrl_o=ctrl_i=8'hA5.
- Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> exactly one cycle pc_write_o=0, ifid_write_o=0, ctrl_o=0; next cycle normal. Repeat with idex_rt_i=0 -> no stall.
- Branch flush: branch_taken_i=1 with no hazard -> ifid_flush_o=1 for one cycle, pc_write_o=1, flush_cnt_o +1 (STALL_CNT_EN).
- Load-use plus branch: both asserted -> bubble inserted, ifid_flush_o=0; flush occurs the following cycle.
- Memory wait: dmem_busy_i high 5 cycles -> pipe_hold_o=1 and pc_write_o=0 for 5 cycles, stall_cnt_o +5; with MAX_WAIT=4, timeout_o rises on the 4th busy cycle and stays high until reset.
- Reset mid-MEM_WAIT: rst_n low while busy -> state INIT, timeout_o=0, counters 0.
